// File: rtl/fwd_pkg.sv
// Shared types and defaults for the operand forwarding / scoreboard unit.
// Optional feature macro used by the top level: FWD_SB_PERF_EN.
package fwd_pkg;

  localparam int FWD_DATA_W = 32;
  localparam int FWD_REG_W  = 5;
  localparam int REG_ZERO   = 0;

  // How a read port obtained its operand this cycle.
  typedef enum logic [1:0] {
    RES_ZERO,
    RES_SRC,
    RES_PEND,
    RES_ORIG
  } res_kind_e;

  function automatic logic is_reg_zero(input logic [FWD_REG_W-1:0] r);
    return r == FWD_REG_W'(REG_ZERO);
  endfunction

endpackage

// File: rtl/fwd_port_resolve.sv
// Operand resolution for one register read port: priority search over the
// forwarding sources, then a fall-back to the in-flight write scoreboard.
module fwd_port_resolve
  import fwd_pkg::*;
#(
  parameter int NSRC   = 3,
  parameter int DATA_W = FWD_DATA_W,
  parameter int REG_W  = FWD_REG_W
) (
  input  logic [REG_W-1:0]       req_reg,
  input  logic [DATA_W-1:0]      req_orig,
  input  logic                   pending,
  input  logic [NSRC-1:0]        src_valid,
  input  logic [NSRC*REG_W-1:0]  src_reg,
  input  logic [NSRC*DATA_W-1:0] src_value,
  output logic [DATA_W-1:0]      value,
  output res_kind_e              kind,
  output logic                   src_wait
);

  logic hit;

  // Lowest source index wins; a matched source hides the scoreboard entirely.
  always_comb begin
    hit      = 1'b0;
    kind     = RES_ORIG;
    value    = req_orig;
    src_wait = 1'b0;
    if (req_reg == REG_W'(REG_ZERO)) begin
      kind  = RES_ZERO;
      value = '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (!hit && (src_reg[i*REG_W +: REG_W] == req_reg)) begin
          hit  = 1'b1;
          kind = RES_SRC;
          if (src_valid[i]) begin
            value = src_value[i*DATA_W +: DATA_W];
          end else begin
            value    = '0;
            src_wait = 1'b1;
          end
        end
      end
      if (!hit && pending) begin
        kind  = RES_PEND;
        value = '0;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Multi-port operand forwarding with a per-register in-flight write scoreboard.
// Define FWD_SB_PERF_EN to add saturating stall performance counters.
module fwd_scoreboard_unit
  import fwd_pkg::*;
#(
  parameter int NPORT  = 2,
  parameter int NSRC   = 3,
  parameter int DATA_W = FWD_DATA_W,
  parameter int REG_W  = FWD_REG_W,
  parameter int CNT_W  = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic                    issue_valid,
  input  logic [REG_W-1:0]        issue_reg,
  output logic                    issue_ready,
  input  logic                    wb_valid,
  input  logic [REG_W-1:0]        wb_reg,
  input  logic [NPORT-1:0]        req_en,
  input  logic [NPORT*REG_W-1:0]  req_reg,
  input  logic [NPORT*DATA_W-1:0] req_orig,
  input  logic [NSRC-1:0]         src_valid,
  input  logic [NSRC*REG_W-1:0]   src_reg,
  input  logic [NSRC*DATA_W-1:0]  src_value,
  output logic [NPORT*DATA_W-1:0] fwd_value,
  output logic                    stall_exec,
  output logic                    sb_err
`ifdef FWD_SB_PERF_EN
  ,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_sb_stall_cnt
`endif
);

  localparam int NREG = 1 << REG_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             sb_err_q, sb_err_d;

  logic             issue_fire, wb_fire;
  logic [NPORT-1:0] pend, src_wait, port_stall;
  res_kind_e        kind [NPORT];

  // A same-cycle writeback to the saturated register frees the slot it needs.
  assign issue_ready = (cnt_q[issue_reg] != CNT_MAX) ||
                       (wb_valid && (wb_reg == issue_reg));
  assign issue_fire  = issue_valid && issue_ready && (issue_reg != REG_W'(REG_ZERO));
  assign wb_fire     = wb_valid && (wb_reg != REG_W'(REG_ZERO));

  always_comb begin
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q;
    if (flush) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_d[i] = '0;
      end
    end else if (!(issue_fire && wb_fire && (issue_reg == wb_reg))) begin
      if (issue_fire) begin
        cnt_d[issue_reg] = cnt_q[issue_reg] + CNT_W'(1);
      end
      if (wb_fire) begin
        if (cnt_q[wb_reg] == '0) begin
          sb_err_d = 1'b1;
        end else begin
          cnt_d[wb_reg] = cnt_q[wb_reg] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      pend[p] = (cnt_q[req_reg[p*REG_W +: REG_W]] != '0);
    end
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    fwd_port_resolve #(
      .NSRC   (NSRC),
      .DATA_W (DATA_W),
      .REG_W  (REG_W)
    ) u_resolve (
      .req_reg   (req_reg[p*REG_W +: REG_W]),
      .req_orig  (req_orig[p*DATA_W +: DATA_W]),
      .pending   (pend[p]),
      .src_valid (src_valid),
      .src_reg   (src_reg),
      .src_value (src_value),
      .value     (fwd_value[p*DATA_W +: DATA_W]),
      .kind      (kind[p]),
      .src_wait  (src_wait[p])
    );
    assign port_stall[p] = src_wait[p] || (kind[p] == RES_PEND);
  end

  assign stall_exec = |(port_stall & req_en);

`ifdef FWD_SB_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_sb_q, perf_sb_d;
  logic        sb_only_stall;

  // Scoreboard-only: stalled, yet no enabled port is waiting on a forwarding source.
  assign sb_only_stall = stall_exec && !(|(src_wait & req_en));

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_sb_d    = perf_sb_q;
    if (stall_exec && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (sb_only_stall && (perf_sb_q != 32'hFFFF_FFFF)) begin
      perf_sb_d = perf_sb_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_stall_q <= '0;
      perf_sb_q    <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_sb_q    <= perf_sb_d;
    end
  end

  assign perf_stall_cnt    = perf_stall_q;
  assign perf_sb_stall_cnt = perf_sb_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Scoreboard-style bench for fwd_scoreboard_unit: directed cases then random traffic,
// with expectations from a behavioural model of in-flight write counts.
module tb_fwd_scoreboard_unit;

  localparam int NPORT  = 2;
  localparam int NSRC   = 3;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 2;
  localparam int MAX_INFLIGHT = 3;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic                    flush;
  logic                    issue_valid;
  logic [REG_W-1:0]        issue_reg;
  logic                    issue_ready;
  logic                    wb_valid;
  logic [REG_W-1:0]        wb_reg;
  logic [NPORT-1:0]        req_en;
  logic [NPORT*REG_W-1:0]  req_reg;
  logic [NPORT*DATA_W-1:0] req_orig;
  logic [NSRC-1:0]         src_valid;
  logic [NSRC*REG_W-1:0]   src_reg;
  logic [NSRC*DATA_W-1:0]  src_value;
  logic [NPORT*DATA_W-1:0] fwd_value;
  logic                    stall_exec;
  logic                    sb_err;
`ifdef FWD_SB_PERF_EN
  logic [31:0]             perf_stall_cnt;
  logic [31:0]             perf_sb_stall_cnt;
`endif

  typedef struct {
    logic [NPORT*DATA_W-1:0] fwd;
    logic                    stall;
    logic                    ready;
    logic                    err;
    logic [31:0]             ps;
    logic [31:0]             psb;
  } exp_t;

  exp_t        expq[$];
  int          pending_m[32];
  bit          err_m;
  int unsigned perf_m, perf_sb_m;
  int          assertions = 0;
  int          failures   = 0;

  fwd_scoreboard_unit #(
    .NPORT(NPORT), .NSRC(NSRC), .DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .req_en      (req_en),
    .req_reg     (req_reg),
    .req_orig    (req_orig),
    .src_valid   (src_valid),
    .src_reg     (src_reg),
    .src_value   (src_value),
    .fwd_value   (fwd_value),
    .stall_exec  (stall_exec),
    .sb_err      (sb_err)
`ifdef FWD_SB_PERF_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_sb_stall_cnt (perf_sb_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic clearModel();
    foreach (pending_m[i]) pending_m[i] = 0;
    err_m     = 1'b0;
    perf_m    = 0;
    perf_sb_m = 0;
  endtask

  // Operand for each port from the architectural rules: youngest matching source,
  // else a pending long-latency write blocks, else the register file value.
  function automatic exp_t computeExpected(output bit any_src_wait);
    exp_t e;
    e.fwd        = '0;
    e.stall      = 1'b0;
    any_src_wait = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      int r;
      int hit;
      logic [DATA_W-1:0] v;
      bit st;
      r   = int'(req_reg[p*REG_W +: REG_W]);
      hit = -1;
      v   = '0;
      st  = 1'b0;
      if (r != 0) begin
        for (int i = 0; i < NSRC; i++)
          if (hit < 0 && int'(src_reg[i*REG_W +: REG_W]) == r) hit = i;
        if (hit >= 0) begin
          if (src_valid[hit]) v = src_value[hit*DATA_W +: DATA_W];
          else begin
            st = 1'b1;
            if (req_en[p]) any_src_wait = 1'b1;
          end
        end else if (pending_m[r] != 0) begin
          st = 1'b1;
        end else begin
          v = req_orig[p*DATA_W +: DATA_W];
        end
      end
      e.fwd[p*DATA_W +: DATA_W] = v;
      if (st && req_en[p]) e.stall = 1'b1;
    end
    e.ready = (pending_m[issue_reg] < MAX_INFLIGHT) || (wb_valid && wb_reg == issue_reg);
    e.err   = err_m;
    e.ps    = perf_m;
    e.psb   = perf_sb_m;
    return e;
  endfunction

  task automatic updateModel(input bit ready);
    bit iss, wb;
    iss = issue_valid && ready && issue_reg != 0;
    wb  = wb_valid && wb_reg != 0;
    if (flush) begin
      foreach (pending_m[i]) pending_m[i] = 0;
    end else if (!(iss && wb && issue_reg == wb_reg)) begin
      if (iss) pending_m[issue_reg]++;
      if (wb) begin
        if (pending_m[wb_reg] == 0) err_m = 1'b1;
        else pending_m[wb_reg]--;
      end
    end
  endtask

  task automatic applyStimulus();
    exp_t e;
    bit sw;
    if (!resetn) clearModel();
    e = computeExpected(sw);
    expq.push_back(e);
    @(posedge clk);
    if (!resetn) clearModel();
    else begin
      if (e.stall && perf_m != 32'hFFFF_FFFF) perf_m++;
      if (e.stall && !sw && perf_sb_m != 32'hFFFF_FFFF) perf_sb_m++;
      updateModel(e.ready);
    end
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setIdle();
    flush = 0; issue_valid = 0; issue_reg = 0; wb_valid = 0; wb_reg = 0;
    req_en = 0; req_reg = 0; req_orig = 0;
    src_valid = 0; src_reg = 0; src_value = 0;
  endtask

  task automatic setReq(input int p, input int r, input logic [31:0] orig, input bit en);
    req_reg[p*REG_W +: REG_W]   = REG_W'(r);
    req_orig[p*DATA_W +: DATA_W] = orig;
    req_en[p]                    = en;
  endtask

  task automatic setSrc(input int i, input int r, input bit vld, input logic [31:0] val);
    src_reg[i*REG_W +: REG_W]    = REG_W'(r);
    src_valid[i]                 = vld;
    src_value[i*DATA_W +: DATA_W] = val;
  endtask

  task automatic issueTo(input int r);
    issue_valid = 1; issue_reg = REG_W'(r);
  endtask

  // Monitor: each cycle that has an expectation queued is checked away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("fwd_value", 128'(fwd_value), 128'(e.fwd));
        checkOutput("stall_exec", 128'(stall_exec), 128'(e.stall));
        checkOutput("issue_ready", 128'(issue_ready), 128'(e.ready));
        checkOutput("sb_err", 128'(sb_err), 128'(e.err));
`ifdef FWD_SB_PERF_EN
        checkOutput("perf_stall_cnt", 128'(perf_stall_cnt), 128'(e.ps));
        checkOutput("perf_sb_stall_cnt", 128'(perf_sb_stall_cnt), 128'(e.psb));
`endif
      end
    end
  end

  initial begin
    setIdle();
    resetn = 0;
    clearModel();
    @(posedge clk);
    #1;
    applyStimulus();
    resetn = 1;

    setIdle(); setReq(0, 5, 32'h1111, 1);
    setSrc(0, 5, 1, 32'hAAAA); setSrc(1, 5, 1, 32'hBBBB); setSrc(2, 0, 0, 32'hCCCC);
    applyStimulus();

    setIdle(); setReq(1, 7, 32'h2222, 1); setSrc(0, 7, 0, 32'h7777);
    applyStimulus();
    req_en[1] = 0;
    applyStimulus();

    setIdle(); issueTo(9); setReq(0, 9, 32'h1234, 1);
    applyStimulus();
    issue_valid = 0;
    applyStimulus();
    applyStimulus();
    wb_valid = 1; wb_reg = 9;
    applyStimulus();
    wb_valid = 0;
    applyStimulus();

    setIdle(); setReq(1, 3, 32'h3333, 1);
    repeat (3) begin issueTo(3); applyStimulus(); end
    issueTo(3); applyStimulus();
    wb_valid = 1; wb_reg = 3; applyStimulus();
    wb_valid = 0; issue_valid = 0; applyStimulus();

    setIdle(); wb_valid = 1; wb_reg = 4; applyStimulus();
    wb_valid = 0; applyStimulus(); applyStimulus();

    setIdle(); issueTo(1); applyStimulus();
    issueTo(2); applyStimulus();
    issue_valid = 0; flush = 1; wb_valid = 1; wb_reg = 2; applyStimulus();
    setIdle(); setReq(0, 1, 32'h0101, 1); setReq(1, 2, 32'h0202, 1); applyStimulus();

    setIdle(); issueTo(6); applyStimulus();
    issue_valid = 0; setReq(0, 6, 32'h6666, 1); applyStimulus();
    resetn = 0; applyStimulus();
    resetn = 1; applyStimulus();

    setIdle(); setReq(0, 0, 32'hDEAD, 1); setSrc(0, 0, 0, 32'hBEEF); applyStimulus();

    repeat (400) begin
      resetn      = ($urandom_range(63) != 0);
      flush       = ($urandom_range(15) == 0);
      issue_valid = 1'($urandom_range(1));
      issue_reg   = REG_W'($urandom_range(7));
      wb_valid    = ($urandom_range(3) == 0);
      wb_reg      = REG_W'($urandom_range(7));
      req_en      = NPORT'($urandom_range(3));
      req_reg     = {REG_W'($urandom_range(7)), REG_W'($urandom_range(7))};
      req_orig    = {$urandom, $urandom};
      src_valid   = NSRC'($urandom_range(7));
      src_reg     = {REG_W'($urandom_range(7)), REG_W'($urandom_range(7)), REG_W'($urandom_range(7))};
      src_value   = {$urandom, $urandom, $urandom};
      applyStimulus();
    end

    resetn = 1;
    setIdle();
    repeat (2) @(negedge clk);
    #1;
    assertions++;
    if (expq.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
